// File: rtl/hamming_secded_enc.sv
// Hamming SEC / SECDED encoder with one registered output stage,
// ready/valid handshakes on both sides, optional single-bit error
// injection and a delivered-codeword counter.
module hamming_secded_enc #(
    parameter  int DATA_W     = 8,
    parameter  int EXT_PARITY = 1,
    // Smallest r with 2^r >= DATA_W + r + 1, valid for DATA_W in 4..57.
    localparam int P          = (DATA_W <= 4)  ? 3 :
                                (DATA_W <= 11) ? 4 :
                                (DATA_W <= 26) ? 5 :
                                (DATA_W <= 57) ? 6 : 7,
    localparam int N          = DATA_W + P,
    localparam int CODE_W     = N + ((EXT_PARITY != 0) ? 1 : 0)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              inject_en,
    input  logic [5:0]        inject_pos,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       word_count
);

    logic [CODE_W-1:0] r_code;
    logic              r_valid;
    logic [15:0]       r_count;

    logic [CODE_W-1:0] w_code;
    logic [CODE_W-1:0] w_flip;
    logic              w_accept;
    logic              w_out_hs;

    // Code positions are 1-based; position pos lives in bit pos-1.
    // Data fills non-power-of-two positions in ascending order, then each
    // parity at 2^k covers every position whose index has bit k set.
    // Parity positions are still zero while parities are computed, and a
    // parity position 2^m never has bit k set for k != m, so order is free.
    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [N-1:0]      c;
        logic [CODE_W-1:0] r;
        logic              par;
        int                j;
        c = '0;
        r = '0;
        j = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[j];
                j++;
            end
        end
        for (int k = 0; k < P; k++) begin
            par = 1'b0;
            for (int pos = 1; pos <= N; pos++) begin
                if (((pos >> k) & 1) != 0) par = par ^ c[pos-1];
            end
            c[(1 << k) - 1] = par;
        end
        r[N-1:0] = c;
        // Overall even parity sits above the Hamming bits when enabled.
        if (CODE_W > N) r[CODE_W-1] = ^c;
        return r;
    endfunction

    // Combinational codeword and injection mask; out-of-range positions
    // simply match no bit, leaving the codeword untouched.
    always_comb begin
        w_code = encode(in_data);
        w_flip = '0;
        for (int b = 0; b < CODE_W; b++) begin
            w_flip[b] = inject_en && (int'(inject_pos) == b);
        end
    end

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_out_hs = r_valid && out_ready;

    // Output register: load on accept (also when draining the previous
    // word in the same cycle), otherwise drop valid once it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code  <= '0;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_code  <= w_code ^ w_flip;
            r_valid <= 1'b1;
        end else if (w_out_hs) begin
            r_valid <= 1'b0;
        end
    end

    // Delivered-codeword counter, free-running wrap at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_out_hs) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign out_code   = r_code;
    assign out_valid  = r_valid;
    assign word_count = r_count;

endmodule

// File: tb/tb_hamming_secded_enc.sv
// Scoreboard bench: a 4-bit SECDED encoder with directed, stall, reset and
// random traffic, plus an 11-bit SEC encoder swept over every data word.
module tb_hamming_secded_enc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: DATA_W=4, EXT_PARITY=1 (CODE_W=8)
    logic        a_rst_n, a_in_valid, a_in_ready, a_inject_en, a_out_valid, a_out_ready;
    logic [3:0]  a_in_data;
    logic [5:0]  a_inject_pos;
    logic [7:0]  a_out_code;
    logic [15:0] a_word_count;

    // DUT B: DATA_W=11, EXT_PARITY=0 (CODE_W=15)
    logic        b_rst_n, b_in_valid, b_in_ready, b_inject_en, b_out_valid, b_out_ready;
    logic [10:0] b_in_data;
    logic [5:0]  b_inject_pos;
    logic [14:0] b_out_code;
    logic [15:0] b_word_count;

    hamming_secded_enc #(.DATA_W(4), .EXT_PARITY(1)) u_a (
        .clk(clk), .rst_n(a_rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .inject_en(a_inject_en), .inject_pos(a_inject_pos),
        .out_code(a_out_code), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .word_count(a_word_count));

    hamming_secded_enc #(.DATA_W(11), .EXT_PARITY(0)) u_b (
        .clk(clk), .rst_n(b_rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .inject_en(b_inject_en), .inject_pos(b_inject_pos),
        .out_code(b_out_code), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .word_count(b_word_count));

    int checks = 0;
    int failures = 0;
    logic [7:0]  q_a[$];
    logic [14:0] q_b[$];
    int   cnt_a = 0, cnt_b = 0;
    logic hold_a = 1'b0, acc_a = 1'b0, hold_b = 1'b0, acc_b = 1'b0;
    logic [7:0]  held_a;
    logic [14:0] held_b;
    logic b_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference: place data, then pick parity bits so the XOR of the
    // positions of all set bits (the syndrome) becomes zero.
    function automatic logic [63:0] ref_enc(input int dw, input int ep, input logic [63:0] d,
                                            input logic inj, input int ipos);
        int p, n, j, syn;
        logic [63:0] c;
        p = 0; j = 0; syn = 0; c = '0;
        while ((1 << p) < dw + p + 1) p++;
        n = dw + p;
        for (int pos = 1; pos <= n; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[j];
                if (d[j]) syn = syn ^ pos;
                j++;
            end
        end
        for (int k = 0; k < p; k++) c[(1 << k) - 1] = syn[k];
        if (ep != 0) c[n] = ^c;
        if (inj && ipos < n + ep) c[ipos] = ~c[ipos];
        return c;
    endfunction

    // Monitor A: handshake-level checks and scoreboard pop/push.
    always @(negedge clk) begin
        logic [63:0] e;
        if (a_rst_n) begin
            chk("a_in_ready", 64'(a_in_ready), 64'(!a_out_valid || a_out_ready));
            chk("a_word_count", 64'(a_word_count), 64'(cnt_a & 32'hFFFF));
            if (acc_a) chk("a_latency", 64'(a_out_valid), 64'd1);
            if (hold_a) begin
                chk("a_hold_valid", 64'(a_out_valid), 64'd1);
                chk("a_hold_code", 64'(a_out_code), 64'(held_a));
            end
            if (a_out_valid && a_out_ready) begin
                if (q_a.size() == 0) chk("a_unexpected_out", 64'd1, 64'd0);
                else chk("a_code", 64'(a_out_code), 64'(q_a.pop_front()));
                cnt_a++;
            end
            hold_a = a_out_valid && !a_out_ready;
            held_a = a_out_code;
            acc_a  = a_in_valid && a_in_ready;
            if (acc_a) begin
                e = ref_enc(4, 1, 64'(a_in_data), a_inject_en, int'(a_inject_pos));
                q_a.push_back(e[7:0]);
            end
        end
    end

    // Monitor B: same scheme for the wide SEC encoder.
    always @(negedge clk) begin
        logic [63:0] e;
        if (b_rst_n) begin
            chk("b_word_count", 64'(b_word_count), 64'(cnt_b & 32'hFFFF));
            if (acc_b) chk("b_latency", 64'(b_out_valid), 64'd1);
            if (hold_b) chk("b_hold_code", 64'(b_out_code), 64'(held_b));
            if (b_out_valid && b_out_ready) begin
                if (q_b.size() == 0) chk("b_unexpected_out", 64'd1, 64'd0);
                else chk("b_code", 64'(b_out_code), 64'(q_b.pop_front()));
                cnt_b++;
            end
            hold_b = b_out_valid && !b_out_ready;
            held_b = b_out_code;
            acc_b  = b_in_valid && b_in_ready;
            if (acc_b) begin
                e = ref_enc(11, 0, 64'(b_in_data), b_inject_en, int'(b_inject_pos));
                q_b.push_back(e[14:0]);
            end
        end
    end

    // One word through DUT A with a direct literal check of the result.
    task automatic a_one(input logic [3:0] d, input logic inj, input logic [5:0] pos,
                         input logic [7:0] exp, input string name);
        a_in_data = d; a_inject_en = inj; a_inject_pos = pos; a_in_valid = 1'b1;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_inject_en = 1'b0;
        chk({name, "_valid"}, 64'(a_out_valid), 64'd1);
        chk(name, 64'(a_out_code), 64'(exp));
        @(posedge clk); #1;
    endtask

    // DUT B driver: all 2048 data words then random injected words,
    // holding each word until it is accepted under random backpressure.
    initial begin
        logic acc;
        wait (b_rst_n === 1'b1);
        for (int i = 0; i < 2048 + 300; i++) begin
            @(posedge clk); #1;
            b_in_valid   = 1'b1;
            b_in_data    = (i < 2048) ? 11'(i) : 11'($urandom);
            b_inject_en  = (i >= 2048) && ($urandom_range(0, 3) != 0);
            b_inject_pos = 6'($urandom_range(0, 17));
            do begin
                b_out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                acc = b_in_valid && b_in_ready;
                if (!acc) begin @(posedge clk); #1; end
            end while (!acc);
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        repeat (4) @(posedge clk);
        b_done = 1'b1;
    end

    initial begin
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_inject_en = 1'b0; a_inject_pos = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_inject_en = 1'b0; b_inject_pos = '0; b_out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_code", 64'(a_out_code), 64'd0);
        chk("rst_word_count", 64'(a_word_count), 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);

        // Release at a falling edge so the very next rising edge may accept.
        @(negedge clk);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        a_one(4'b1011, 1'b0, 6'd0, 8'h55, "dir_1011");
        chk("dir_count1", 64'(a_word_count), 64'd1);
        a_one(4'b0001, 1'b0, 6'd0, 8'h87, "dir_0001");
        a_one(4'b0000, 1'b1, 6'd2, 8'h04, "dir_inj2");
        a_one(4'b0000, 1'b1, 6'd9, 8'h00, "dir_inj9");
        a_one(4'b0000, 1'b1, 6'd7, 8'h80, "dir_inj7");

        // Stall: the first word is held while in_valid stays high.
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 4'b0110;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            a_in_data = 4'($urandom); a_inject_en = 1'($urandom);
            chk("stall_in_ready", 64'(a_in_ready), 64'd0);
            @(posedge clk); #1;
        end
        a_out_ready = 1'b1; a_in_valid = 1'b0; a_inject_en = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("stall_count", 64'(a_word_count), 64'd6);

        // Continuous streaming over every data word and injection position.
        a_in_valid = 1'b1;
        for (int d = 0; d < 16; d++) begin
            for (int p = 0; p < 10; p++) begin
                a_in_data = 4'(d); a_inject_en = (p != 9); a_inject_pos = 6'(p);
                @(posedge clk); #1;
                chk("stream_valid", 64'(a_out_valid), 64'd1);
            end
        end
        a_in_valid = 1'b0; a_inject_en = 1'b0;
        @(posedge clk); #1;

        // Random traffic and backpressure.
        for (int i = 0; i < 400; i++) begin
            a_in_valid   = 1'($urandom);
            a_in_data    = 4'($urandom);
            a_inject_en  = ($urandom_range(0, 3) == 0);
            a_inject_pos = 6'($urandom_range(0, 11));
            a_out_ready  = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0; a_inject_en = 1'b0; a_out_ready = 1'b1;
        repeat (3) @(posedge clk); #1;

        // Asynchronous reset while a word is stalled.
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 4'b1111;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(posedge clk); #2;
        a_rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(a_out_valid), 64'd0);
        chk("arst_word_count", 64'(a_word_count), 64'd0);
        chk("arst_out_code", 64'(a_out_code), 64'd0);
        chk("arst_in_ready", 64'(a_in_ready), 64'd1);
        q_a.delete(); cnt_a = 0; hold_a = 1'b0; acc_a = 1'b0;
        #1;
        a_rst_n = 1'b1;
        a_out_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("post_rst_valid", 64'(a_out_valid), 64'd0);
        chk("post_rst_count", 64'(a_word_count), 64'd0);
        a_one(4'b1011, 1'b0, 6'd0, 8'h55, "post_rst_1011");

        for (int t = 0; t < 20000 && !b_done; t++) @(posedge clk);
        chk("b_done_timeout", 64'(b_done), 64'd1);
        repeat (2) @(posedge clk);
        chk("a_queue_drained", 64'(q_a.size()), 64'd0);
        chk("b_queue_drained", 64'(q_b.size()), 64'd0);
        chk("b_all_delivered", 64'(cnt_b), 64'd2348);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
